sipo_rx: RTL and testbench
==========================

Name: sipo_rx

Overview:
- Serial-in/parallel-out receiver. It is the consumer-side counterpart of the stepper-driver serial transmit stage.
- Samples one serial bit per clock, MSB first, while a framing strobe is active. Assembles SIZE-bit words and presents each completed word on a valid/ack handshake to the register/command logic.
- Flags framing aborts and unacknowledged-word overruns.

Parameters:
- SIZE, 8, word width in bits; must be >= 2.

Ports:
- clk_in  input  1  system clock; all sampling on rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data bit, sampled every clock while frame_n_in = 0.
- frame_n_in  input  1  active-low framing strobe; low = bits are valid.
- ack_in  input  1  consumer acknowledges the word currently on data_out.
- clear_ovr_in  input  1  clears the sticky overrun flag.
- data_out  output  SIZE  last completed word; bit SIZE-1 is the first bit received.
- valid_out  output  1  data_out holds an unacknowledged word.
- busy_out  output  1  a word is partially received.
- abort_out  output  1  one-cycle pulse: frame ended mid-word.
- overrun_out  output  1  sticky: a word completed while the previous one was still unacknowledged.
- parity_err_out  output  1  parity status of the word on data_out (optional feature only).

Behaviour:
- Clock and reset: single clock clk_in; reset_n_in is asynchronous, active-low.
- Reset (asynchronous, any time, including mid-word):
  - data_out = 0, valid_out = 0, busy_out = 0, abort_out = 0, overrun_out = 0, parity_err_out = 0.
  - Bit counter = SIZE-1; state = IDLE; partial shift register = 0.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - Edge with frame_n_in = 0: store serial_in at bit SIZE-1, counter <= SIZE-2, go to SHIFT, busy_out <= 1.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge with frame_n_in = 0 stores serial_in at bit [counter] and decrements the counter.
  - Edge sampling bit 0 (counter = 0):
    - data_out <= assembled word, including that bit.
    - valid_out <= 1, busy_out <= 0, counter <= SIZE-1, state <= IDLE.
  - Latency: the word appears on data_out at the same edge that samples its last bit. A frame held low for SIZE edges gives valid_out = 1 after edge SIZE.
- Back-to-back words: if frame_n_in stays low, the edge after completion samples bit SIZE-1 of the next word. There are no gap cycles; the counter wraps SIZE-1 -> 0 -> SIZE-1.
- Abort: frame_n_in = 1 on an edge while in SHIFT:
  - Partial word discarded; counter <= SIZE-1; state <= IDLE; busy_out <= 0.
  - abort_out = 1 for exactly one cycle; data_out and valid_out unchanged.
- Handshake:
  - valid_out stays high until an edge with ack_in = 1, then clears.
  - ack_in while valid_out = 0 is ignored.
- Overrun: a word completes while valid_out = 1 and ack_in = 0 on that edge:
  - The new word is dropped; data_out keeps the old word.
  - overrun_out <= 1, held until clear_ovr_in = 1.
- Simultaneous events:
  - Word completion with ack_in = 1 on the same edge: new word loads, valid_out stays 1, no overrun.
  - Overrun set and clear_ovr_in on the same edge: set wins.
- Without the optional feature, parity_err_out is constant 0.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined:
  - After bit 0, SHIFT goes to PARITY; busy_out remains 1.
  - The next edge with frame_n_in = 0 samples an even-parity bit. Then:
    - The word loads to data_out and valid_out <= 1.
    - parity_err_out <= 1 if XOR(word, parity bit) = 1, else 0.
    - parity_err_out is updated only when data_out loads.
  - Overrun rule and ack rule apply at this edge.
  - frame_n_in = 1 in PARITY counts as an abort.
  - Frame length is SIZE+1 edges.
- Not defined: no PARITY state; parity_err_out tied 0; frame length is SIZE edges.

Test Plan:
- Reset, then frame_n_in low for 8 edges with serial bits 1,0,1,0,0,1,0,1 -> data_out = 8'hA5 and valid_out = 1 after edge 8; busy_out = 1 during edges 1-7.
- Frame held low for 16 edges sending 8'h3C then 8'hC3, ack_in pulsed at edge 9 -> data_out = 8'h3C after edge 8, 8'hC3 after edge 16; overrun_out stays 0.
- Same 16-edge stream with no ack_in -> data_out stays 8'h3C; overrun_out = 1 after edge 16; clear_ovr_in pulse -> overrun_out = 0.
- frame_n_in high after 5 bits -> abort_out high for 1 cycle, valid_out unchanged; next full frame of 8'h0F -> data_out = 8'h0F.
- reset_n_in low after bit 4 of a word, released, then frame 8'hFF -> all outputs 0 during reset; data_out = 8'hFF after 8 new edges, with no residual bits from the aborted word.
- With SIPO_RX_PARITY_EN: 8'hA5 plus parity bit 0 -> parity_err_out = 0; 8'hA5 plus parity bit 1 -> parity_err_out = 1; valid_out appears after edge 9.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: MSB-first framed bit stream to SIZE-bit words on a valid/ack handshake.
// Optional even-parity bit per word is enabled by defining SIPO_RX_PARITY_EN.
module sipo_rx #(
    parameter int SIZE = 8
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            serial_in,
    input  logic            frame_n_in,
    input  logic            ack_in,
    input  logic            clear_ovr_in,
    output logic [SIZE-1:0] data_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            abort_out,
    output logic            overrun_out,
    output logic            parity_err_out
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] CNT_TOP    = CW'(SIZE - 1);
    localparam logic [CW-1:0] CNT_SECOND = CW'(SIZE - 2);

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] word_next;
    logic            complete;
    logic            abort_evt;
`ifdef SIPO_RX_PARITY_EN
    logic            perr_next;
`endif

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!frame_n_in) state_next = SHIFT;
            end
            SHIFT: begin
                if (frame_n_in) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
`ifdef SIPO_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef SIPO_RX_PARITY_EN
            PARITY: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Event decode: completion, abort and the word that would load
    always_comb begin
        complete  = 1'b0;
        abort_evt = 1'b0;
        word_next = shreg;
`ifdef SIPO_RX_PARITY_EN
        perr_next = 1'b0;
`endif
        unique case (state)
            IDLE: ;
            SHIFT: begin
                abort_evt = frame_n_in;
`ifndef SIPO_RX_PARITY_EN
                // last data bit is merged combinationally so the word loads on the edge that samples it
                complete     = !frame_n_in && (cnt == '0);
                word_next[0] = serial_in;
`endif
            end
`ifdef SIPO_RX_PARITY_EN
            PARITY: begin
                abort_evt = frame_n_in;
                complete  = !frame_n_in;
                perr_next = ^{shreg, serial_in};
            end
`endif
            default: ;
        endcase
    end

    // Shift register, bit counter and handshake outputs
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shreg       <= '0;
            cnt         <= CNT_TOP;
            data_out    <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            abort_out   <= 1'b0;
            overrun_out <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err_out <= 1'b0;
`endif
        end else begin
            abort_out <= abort_evt;
            busy_out  <= (state_next != IDLE);

            unique case (state)
                IDLE: begin
                    if (!frame_n_in) begin
                        shreg[SIZE-1] <= serial_in;
                        cnt           <= CNT_SECOND;
                    end
                end
                SHIFT: begin
                    if (frame_n_in) begin
                        shreg <= '0;
                        cnt   <= CNT_TOP;
                    end else begin
                        shreg[cnt] <= serial_in;
                        cnt        <= (cnt == '0) ? CNT_TOP : cnt - CW'(1);
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    if (frame_n_in) shreg <= '0;
                end
`endif
                default: ;
            endcase

            if (complete) begin
                if (!valid_out || ack_in) begin
                    data_out  <= word_next;
                    valid_out <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
                    parity_err_out <= perr_next;
`endif
                end
            end else if (ack_in) begin
                valid_out <= 1'b0;
            end

            if (complete && valid_out && !ack_in) begin
                overrun_out <= 1'b1;
            end else if (clear_ovr_in) begin
                overrun_out <= 1'b0;
            end
        end
    end

`ifndef SIPO_RX_PARITY_EN
    assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: a bit-queue reference model predicts words and status,
// a monitor checks each presented word and the per-cycle status flags.
module tb_sipo_rx;

    localparam int SIZE = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME = SIZE + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = SIZE;
    localparam bit PAR   = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            serial = 1'b0;
    logic            frame_n = 1'b1;
    logic            ack = 1'b0;
    logic            clr = 1'b0;
    logic [SIZE-1:0] data;
    logic            valid, busy, abort_p, ovr, perr;

    always #5 clk = ~clk;

    sipo_rx #(.SIZE(SIZE)) dut (
        .clk_in        (clk),
        .reset_n_in    (reset_n),
        .serial_in     (serial),
        .frame_n_in    (frame_n),
        .ack_in        (ack),
        .clear_ovr_in  (clr),
        .data_out      (data),
        .valid_out     (valid),
        .busy_out      (busy),
        .abort_out     (abort_p),
        .overrun_out   (ovr),
        .parity_err_out(perr)
    );

    typedef struct packed {
        logic [SIZE-1:0] word;
        logic            perr;
    } exp_t;

    exp_t exp_q[$];
    bit   bits_q[$];
    bit   m_valid, m_ovr, m_busy, m_abort;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        m_valid = 0;
        m_ovr   = 0;
        m_busy  = 0;
        m_abort = 0;
    endtask

    // Drive one clock of inputs and predict the effect of the following rising edge
    task automatic step(input logic f, input logic b, input logic a, input logic c);
        logic [SIZE-1:0] w;
        logic            p;
        logic            done;
        logic            set_ovr;
        @(negedge clk);
        frame_n = f;
        serial  = b;
        ack     = a;
        clr     = c;
        done    = 1'b0;
        w       = '0;
        p       = 1'b0;
        m_abort = 1'b0;
        if (f) begin
            m_abort = (bits_q.size() != 0);
            bits_q.delete();
        end else begin
            bits_q.push_back(b);
            if (bits_q.size() == FRAME) begin
                for (int unsigned i = 0; i < SIZE; i++) w[SIZE-1-i] = bits_q[i];
                if (PAR) for (int unsigned i = 0; i < FRAME; i++) p ^= bits_q[i];
                done = 1'b1;
                bits_q.delete();
            end
        end
        set_ovr = done && m_valid && !a;
        if (done) begin
            if (!m_valid || a) begin
                exp_q.push_back('{word: w, perr: p});
                m_valid = 1;
            end
        end else if (a) begin
            m_valid = 0;
        end
        if (set_ovr) m_ovr = 1;
        else if (c) m_ovr = 0;
        m_busy = (bits_q.size() != 0);
    endtask

    task automatic send_word(input logic [SIZE-1:0] w, input logic ack_first, input logic bad_par);
        for (int unsigned i = 0; i < SIZE; i++)
            step(1'b0, w[SIZE-1-i], (i == 0) ? ack_first : 1'b0, 1'b0);
        if (PAR) step(1'b0, (^w) ^ bad_par, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_abort"}, 32'(abort_p), 0);
        check({tag, "_ovr"}, 32'(ovr), 0);
        check({tag, "_perr"}, 32'(perr), 0);
    endtask

    // Monitor: a word is presented when valid rises, or stays high right after an ack edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (valid && (!prev_valid || ack)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_word actual=%0h required=none at %0t", data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 32'(data), 32'(e.word));
                        check("word_perr", 32'(perr), 32'(e.perr));
                    end
                end
                check("valid", 32'(valid), 32'(m_valid));
                check("busy", 32'(busy), 32'(m_busy));
                check("abort", 32'(abort_p), 32'(m_abort));
                check("overrun", 32'(ovr), 32'(m_ovr));
                prev_valid = valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Single word
        send_word(8'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back with ack during the second word
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hC3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back without ack: overrun, then clear
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after 5 bits while the previous word is still unacknowledged
        for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Async reset in the middle of a word
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        frame_n = 1'b1;
        model_reset();
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_word(8'hFF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Parity good and bad (plain word pair in the default build)
        send_word(8'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int unsigned i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0));

        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
